dcache_miss_ctrl: RTL



---
 rtl/dcache_miss_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: tag lookup, dirty-victim writeback,
// line refill over a beat-based memory port, and tag allocation.
module dcache_miss_ctrl #(
    parameter int DP    = 4,
    parameter int TW    = 20,
    parameter int BEATS = 4,
    parameter int AW    = $clog2(DP),
    parameter int BW    = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [TW-1:0] req_tag,
    output logic          resp_valid,
    output logic          resp_hit,
    output logic [AW-1:0] resp_index,
    input  logic          flush_req,
    output logic          flush,
    output logic [TW-1:0] tag_cmp_data,
    input  logic [DP-1:0] tag_hit,
    input  logic [AW-1:0] tag_hindex,
    input  logic          tag_hdirty,
    input  logic [AW-1:0] tag_wptr,
    input  logic          tag_cval,
    input  logic          tag_cdirty,
    input  logic [TW-1:0] tag_ctag,
    output logic          tag_wr,
    output logic          tag_uwr,
    output logic [AW-1:0] tag_uptr,
    output logic [TW+1:0] tag_wdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [TW-1:0] mem_tag,
    output logic [BW-1:0] mem_beat,
    input  logic          mem_ack,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, ALLOC} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tag_q;
    logic          we_q;
    logic [AW-1:0] victim_idx;
    logic [TW-1:0] victim_tag;
    logic [BW-1:0] beat;

    logic hit, accept, in_mem, last_beat;

    assign hit       = |tag_hit;
    assign accept    = (state == IDLE) && req_valid && !flush_req;
    assign in_mem    = (state == WB) || (state == REFILL);
    assign last_beat = in_mem && mem_ack && (beat == BW'(BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q      <= '0;
            we_q       <= 1'b0;
            victim_idx <= '0;
            victim_tag <= '0;
            beat       <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            if (accept) begin
                tag_q <= req_tag;
                we_q  <= req_we;
            end
            if (state == LOOKUP && !hit) begin
                victim_idx <= tag_wptr;
                victim_tag <= tag_ctag;
            end
            if (in_mem && mem_ack) begin
                beat <= last_beat ? '0 : beat + 1'b1;
            end
            if (flush) begin
                hit_cnt  <= '0;
                miss_cnt <= '0;
            end else if (state == LOOKUP) begin
                // Counters stick at all-ones rather than wrapping.
                if (hit && hit_cnt != 16'hFFFF)
                    hit_cnt <= hit_cnt + 16'd1;
                if (!hit && miss_cnt != 16'hFFFF)
                    miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = LOOKUP;
            LOOKUP: begin
                if (hit)                        state_nx = IDLE;
                else if (tag_cval && tag_cdirty) state_nx = WB;
                else                            state_nx = REFILL;
            end
            WB:      if (last_beat) state_nx = REFILL;
            REFILL:  if (last_beat) state_nx = ALLOC;
            ALLOC:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        flush      = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_index = '0;
        tag_wr     = 1'b0;
        tag_uwr    = 1'b0;
        tag_uptr   = '0;
        tag_wdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_tag    = '0;
        mem_beat   = '0;
        unique case (state)
            IDLE: begin
                req_ready = !flush_req;
                flush     = flush_req;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    resp_index = tag_hindex;
                    // Stores to clean lines mark them dirty in place.
                    if (we_q && !tag_hdirty) begin
                        tag_uwr   = 1'b1;
                        tag_uptr  = tag_hindex;
                        tag_wdata = {1'b1, 1'b1, tag_q};
                    end
                end
            end
            WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_tag  = victim_tag;
                mem_beat = beat;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_tag  = tag_q;
                mem_beat = beat;
            end
            ALLOC: begin
                tag_wr     = 1'b1;
                tag_wdata  = {1'b1, we_q, tag_q};
                resp_valid = 1'b1;
                resp_index = victim_idx;
            end
            default: ;
        endcase
    end

    assign tag_cmp_data = tag_q;

endmodule
